// File: rtl/jpeg_rle_pkg.sv
// jpeg_rle_pkg: shared constants, FSM states and symbol layout for the JPEG run-length block decoder
package jpeg_rle_pkg;
  localparam int COEF_W_DEF = 12;
  localparam int AMP_BITS = 11;
  localparam logic [5:0] BLK_LAST = 6'd63;
  localparam logic [3:0] EOB_RUN = 4'd0;
  localparam logic [3:0] EOB_SIZE = 4'd0;
  localparam logic [3:0] ZRL_RUN = 4'd15;
  localparam logic [3:0] ZRL_SIZE = 4'd0;
  localparam logic [3:0] DC_SIZE_MAX = 4'd11;
  localparam logic [3:0] AC_SIZE_MAX = 4'd10;
  typedef enum logic [2:0] {S_DC, S_AC, S_ZERO, S_VAL, S_FILL} state_t;
  typedef struct packed {
    logic [3:0] run;
    logic [3:0] size;
    logic [AMP_BITS-1:0] amp;
  } sym_t;
endpackage

// File: rtl/jpeg_rle_block_decoder_amp.sv
// jpeg_amp_decode: JPEG size/amplitude bits to a sign-extended coefficient value
module jpeg_amp_decode
  import jpeg_rle_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int AMP_W = AMP_BITS
) (
  input  logic [3:0]        i_size,
  input  logic [AMP_W-1:0]  i_amp,
  output logic [COEF_W-1:0] o_value
);
  logic [AMP_W-1:0] w_mask, w_amp;
  logic w_neg;
  assign w_mask = (AMP_W'(1) << i_size) - AMP_W'(1);
  assign w_amp = i_amp & w_mask;
  // a clear top bit of the size field marks a negative amplitude
  assign w_neg = ~|(w_amp & ~(w_mask >> 1));
  assign o_value = w_neg ? COEF_W'(w_amp) - COEF_W'(w_mask) : COEF_W'(w_amp);
endmodule

// File: rtl/jpeg_rle_block_decoder.sv
// jpeg_rle_block_decoder: expands DC/AC entropy symbols into 64 zigzag-ordered coefficients
// Optional DC prediction with restart clear is enabled by defining JPEG_DC_PRED_EN.
module jpeg_rle_block_decoder
  import jpeg_rle_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int AMP_W = AMP_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [3:0]        sym_run,
  input  logic [3:0]        sym_size,
  input  logic [AMP_W-1:0]  sym_amp,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [5:0]        coef_idx,
  output logic              coef_last,
  output logic              err_overrun,
  input  logic              dc_pred_clr
);
  state_t r_state, w_state;
  logic [5:0] r_idx, w_idx, r_ci, w_ci;
  logic [4:0] r_run, w_run;
  logic r_zrl, w_zrl, r_err, w_err, r_live, r_cv, w_cv, r_cl, w_cl;
  logic [COEF_W-1:0] r_val, w_val, r_cd, w_cd, w_amp, w_diff, w_dc;
  logic w_acc, w_eob, w_zrl_sym, w_bad;
  sym_t w_sym;
  assign w_sym = '{run: sym_run, size: sym_size, amp: AMP_BITS'(sym_amp)};
  jpeg_amp_decode #(.COEF_W(COEF_W), .AMP_W(AMP_W)) u_amp (
    .i_size (w_sym.size),
    .i_amp  (AMP_W'(w_sym.amp)),
    .o_value(w_amp)
  );
  // a stalled output register freezes everything, so acceptance needs coef_ready
  assign sym_ready = r_live && coef_ready && (r_state == S_DC || r_state == S_AC);
  assign w_acc = sym_valid && sym_ready;
  assign w_eob = w_sym.run == EOB_RUN && w_sym.size == EOB_SIZE;
  assign w_zrl_sym = w_sym.run == ZRL_RUN && w_sym.size == ZRL_SIZE;
  assign w_bad = (w_sym.size == 4'd0 && !w_eob && !w_zrl_sym) || w_sym.size > AC_SIZE_MAX;
  assign w_diff = (w_sym.size > DC_SIZE_MAX) ? '0 : w_amp;
`ifdef JPEG_DC_PRED_EN
  logic [COEF_W-1:0] r_pred;
  assign w_dc = (dc_pred_clr ? '0 : r_pred) + w_diff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pred <= '0;
    else if (w_acc && r_state == S_DC) r_pred <= w_dc;
    else if (dc_pred_clr) r_pred <= '0;
`else
  logic w_unused;
  assign w_unused = dc_pred_clr;
  assign w_dc = w_diff;
`endif
  always_comb begin
    w_state = r_state;
    w_idx = r_idx;
    w_run = r_run;
    w_zrl = r_zrl;
    w_val = r_val;
    w_err = r_err;
    w_cv = r_cv;
    w_cd = r_cd;
    w_ci = r_ci;
    w_cl = r_cl;
    if (coef_ready) begin
      w_cv = 1'b0;
      case (r_state)
        S_DC: if (w_acc) begin
          w_cv = 1'b1;
          w_cd = w_dc;
          w_ci = 6'd0;
          w_cl = 1'b0;
          w_idx = 6'd1;
          w_state = S_AC;
          w_err = r_err | (w_sym.size > DC_SIZE_MAX);
        end
        S_AC: if (w_acc) begin
          w_zrl = w_zrl_sym;
          w_run = w_zrl_sym ? 5'd16 : {1'b0, w_sym.run};
          w_val = w_amp;
          w_err = r_err | w_bad;
          w_state = w_zrl_sym ? S_ZERO : (w_bad || w_eob) ? S_FILL : (w_sym.run != 4'd0) ? S_ZERO : S_VAL;
        end
        default: begin
          w_cv = 1'b1;
          w_cd = (r_state == S_VAL) ? r_val : '0;
          w_ci = r_idx;
          w_cl = r_idx == BLK_LAST;
          w_idx = r_idx + 6'd1;
          w_run = r_run - 5'd1;
          if (r_idx == BLK_LAST) begin
            w_state = S_DC;
            w_idx = 6'd0;
            w_err = r_err | (r_state == S_ZERO && (r_run != 5'd1 || !r_zrl));
          end else if (r_state == S_VAL) w_state = S_AC;
          else if (r_state == S_ZERO && r_run == 5'd1) w_state = r_zrl ? S_AC : S_VAL;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_DC;
      r_idx <= '0;
      r_run <= '0;
      r_zrl <= 1'b0;
      r_val <= '0;
      r_err <= 1'b0;
      r_live <= 1'b0;
      r_cv <= 1'b0;
      r_cd <= '0;
      r_ci <= '0;
      r_cl <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx <= w_idx;
      r_run <= w_run;
      r_zrl <= w_zrl;
      r_val <= w_val;
      r_err <= w_err;
      r_live <= 1'b1;
      r_cv <= w_cv;
      r_cd <= w_cd;
      r_ci <= w_ci;
      r_cl <= w_cl;
    end
  assign coef_valid = r_cv;
  assign coef_data = r_cd;
  assign coef_idx = r_ci;
  assign coef_last = r_cl;
  assign err_overrun = r_err;
endmodule
